// File: rtl/dbi_pkg.sv
// dbi_pkg: shared DBI helpers (popcount, DC-rule check, width legality)
package dbi_pkg;
  localparam int MAX_WIDTH = 256;
  function automatic int popcount(input logic [MAX_WIDTH-1:0] word);
    int p = 0;
    for (int i = 0; i < MAX_WIDTH; i++) p += int'(word[i]);
    return p;
  endfunction
  function automatic logic dbi_dc_violation(input logic [MAX_WIDTH-1:0] word, input logic flag, input int width);
    int p = popcount(word);
    return (p > width / 2) || (flag && p == width / 2);
  endfunction
  function automatic bit width_ok(input int width);
    return width >= 2 && width % 2 == 0 && width <= MAX_WIDTH;
  endfunction
endpackage

// File: rtl/dbi_skid_buffer.sv
// dbi_skid_buffer: output register plus one-entry skid, registered in_ready
module dbi_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  assign in_ready = ~skid_valid;
  // skid drains into the output first; a beat arriving while the output is held parks in skid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (~out_valid | out_ready) begin
      out_valid  <= skid_valid | in_valid;
      skid_valid <= 1'b0;
      if (skid_valid | in_valid) out_data <= skid_valid ? skid_data : in_data;
    end else if (in_valid & ~skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
endmodule

// File: rtl/dbi_decoder.sv
// dbi_decoder: DBI receive decoder with DC-rule check, skid-buffered stream and saturating counters
module dbi_decoder
  import dbi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_dbi,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clr_counts,
  output logic [COUNT_WIDTH-1:0] inv_count,
  output logic [COUNT_WIDTH-1:0] err_count
);
  if (!width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("dbi_decoder: DATA_WIDTH must be even, >= 2 and <= MAX_WIDTH");
  end
  logic [MAX_WIDTH-1:0] word_ext;
  logic                 err;
  logic                 accept;
  // zero-extend the received word so the shared package helpers can see it
  always_comb begin
    word_ext                   = '0;
    word_ext[DATA_WIDTH-1:0]   = in_data;
  end
  assign err    = dbi_dc_violation(word_ext, in_dbi, DATA_WIDTH);
  assign accept = in_valid & in_ready;
  dbi_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({err, in_dbi ? ~in_data : in_data}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data ({out_err, out_data}),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  // saturating statistics on accepted beats; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inv_count <= '0;
      err_count <= '0;
    end else begin
      inv_count <= clr_counts ? '0 : (accept & in_dbi & ~&inv_count) ? inv_count + 1'b1 : inv_count;
      err_count <= clr_counts ? '0 : (accept & err & ~&err_count) ? err_count + 1'b1 : err_count;
    end
endmodule

// File: tb/tb_dbi_decoder.sv
// tb_dbi_decoder: vector table, directed sequences and random traffic against a queue model
module tb_dbi_decoder;
  localparam int W = 8;
  localparam int CW = 4;
  localparam int MAXC = 15;
  logic          clk = 0;
  logic          rst_n = 0;
  logic [W-1:0]  in_data = '0;
  logic          in_dbi = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          out_valid;
  logic          out_ready = 0;
  logic          clr_counts = 0;
  logic [CW-1:0] inv_count;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  dbi_decoder #(.DATA_WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dbi(in_dbi), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .clr_counts(clr_counts), .inv_count(inv_count), .err_count(err_count)
  );

  typedef struct packed {logic [W-1:0] d; logic e;} beat_t;
  typedef struct {logic [W-1:0] d; logic f; logic [W-1:0] xd; logic xe;} vec_t;

  beat_t q[$];
  beat_t got[$];
  int    m_inv = 0, m_err = 0;
  int    checks = 0, errors = 0;
  bit    last_acc;

  function automatic beat_t ref_beat(input logic [W-1:0] d, input logic f);
    int p = $countones(d);
    beat_t b;
    b.d = f ? ~d : d;
    b.e = (p > W / 2) || (f && p == W / 2);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_err", 32'(out_err), 32'(q[0].e));
    end
    chk("inv_count", 32'(inv_count), 32'(m_inv));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic f, input logic r, input logic c);
    bit pop;
    beat_t b;
    in_valid = v; in_data = d; in_dbi = f; out_ready = r; clr_counts = c;
    b = ref_beat(d, f);
    last_acc = v && q.size() < 2;
    pop = q.size() > 0 && r;
    @(posedge clk);
    if (pop) got.push_back(q.pop_front());
    if (last_acc) q.push_back(b);
    if (c) begin
      m_inv = 0;
      m_err = 0;
    end else if (last_acc) begin
      if (f && m_inv < MAXC) m_inv++;
      if (b.e && m_err < MAXC) m_err++;
    end
    #1 check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) cycle(0, '0, 0, 1, 0);
    chk("drained", 32'(q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int   idx, cyc;
    vt[0] = '{8'hF1, 1'b0, 8'hF1, 1'b1};
    vt[1] = '{8'h0F, 1'b1, 8'hF0, 1'b1};
    vt[2] = '{8'h0F, 1'b0, 8'h0F, 1'b0};
    vt[3] = '{8'h03, 1'b0, 8'h03, 1'b0};
    vt[4] = '{8'h07, 1'b1, 8'hF8, 1'b0};
    vt[5] = '{8'hFF, 1'b1, 8'h00, 1'b1};
    vt[6] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vt[7] = '{8'h55, 1'b1, 8'hAA, 1'b1};
    vt[8] = '{8'h1F, 1'b0, 8'h1F, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_err", 32'(out_err), 0);
    rst_n = 1;
    @(posedge clk);
    #1 check_state();

    for (int i = 0; i < 9; i++) begin
      cycle(1, vt[i].d, vt[i].f, 1, 0);
      chk("vec_data", 32'(out_data), 32'(vt[i].xd));
      chk("vec_err", 32'(out_err), 32'(vt[i].xe));
      if (i == 2) chk("vec_err_count", 32'(err_count), 2);
      if (i == 4) chk("vec_inv_count", 32'(inv_count), 2);
    end
    drain();

    got.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 10 || q.size() > 0) && cyc < 50) begin
      cycle(idx < 10, 8'(8'h10 + idx), 0, !(cyc >= 3 && cyc <= 5), 0);
      if (cyc == 3) chk("bp_in_ready_drop", 32'(in_ready), 0);
      if (last_acc) idx++;
      cyc++;
    end
    chk("bp_count", 32'(got.size()), 10);
    for (int i = 0; i < got.size(); i++) chk("bp_order", 32'(got[i].d), 32'(8'h10 + i));

    got.delete();
    for (int i = 0; i < 100; i++) begin
      cycle(1, 8'($urandom), 1'($urandom), 1, 0);
      chk("tp_out_valid", 32'(out_valid), 1);
    end
    drain();
    chk("tp_count", 32'(got.size()), 100);

    cycle(0, '0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(1, 8'h01, 1, 1, 0);
    chk("sat_inv", 32'(inv_count), 15);
    cycle(1, 8'h01, 1, 1, 1);
    chk("clr_priority", 32'(inv_count), 0);
    drain();

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    drain();

    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h44, 1, 0, 0);
    chk("pre_reset_full", 32'(q.size()), 2);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_inv", 32'(inv_count), 0);
    chk("async_err", 32'(err_count), 0);
    q.delete();
    m_inv = 0;
    m_err = 0;
    @(posedge clk);
    #1 rst_n = 1;
    check_state();
    chk("post_reset_in_ready", 32'(in_ready), 1);
    cycle(1, 8'hA5, 0, 1, 0);
    chk("post_reset_data", 32'(out_data), 32'(8'hA5));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
